// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered decode control stage with D/E pipeline register
// Decodes opcode/fun in D and sequences multi-cycle multiplies by stalling the front-end.
module ctrl_decode_stage #(
   parameter int ALU_CTRL_W = 4,
   parameter int MUL_CYCLES = 3,
   parameter int TARGET_W   = 26
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_D,
   input  logic [5:0]            opcode_D,
   input  logic [5:0]            fun_D,
   input  logic [TARGET_W-1:0]   target_D,
   input  logic                  stall_E,
   input  logic                  flush_E,
   output logic                  stall_D,
   output logic                  valid_E,
   output logic                  Jump_E,
   output logic                  Branch_E,
   output logic                  Branch_ne_E,
   output logic                  RegW_enable_E,
   output logic                  Extend_enable_E,
   output logic                  ALU_src_E,
   output logic [ALU_CTRL_W-1:0] ALU_control_E,
   output logic                  Mem_Write_E,
   output logic                  Result_src_E,
   output logic [TARGET_W-1:0]   target_E,
   output logic                  illegal_E
);

   localparam logic [5:0] OP_R    = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100001;
   localparam logic [5:0] OP_BEQ  = 6'b100010;
   localparam logic [5:0] OP_BNE  = 6'b100011;
   localparam logic [5:0] OP_ADDI = 6'b100100;
   localparam logic [5:0] OP_ANDI = 6'b100101;
   localparam logic [5:0] OP_ORI  = 6'b100110;
   localparam logic [5:0] OP_SLTI = 6'b100111;
   localparam logic [5:0] OP_J    = 6'b000000;
   localparam logic [5:0] FUN_MUL = 6'h06;
   localparam logic [5:0] FUN_MAX = 6'h0D;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(1);
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(5);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(7);

   localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
   localparam logic [3:0] CNT_INIT  = 4'(MUL_CYCLES - 1);

   typedef struct packed {
      logic                  valid;
      logic                  jump;
      logic                  branch;
      logic                  branch_ne;
      logic                  regw;
      logic                  ext;
      logic                  alu_src;
      logic [ALU_CTRL_W-1:0] alu;
      logic                  mem_write;
      logic                  result_src;
      logic [TARGET_W-1:0]   target;
      logic                  illegal;
   } ctrl_t;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   ctrl_t      dec;
   ctrl_t      ctrl_d, ctrl_q;
   state_t     state_d, state_q;
   logic [3:0] cnt_d, cnt_q;
   logic       mul_dec;

   always_comb begin
      dec = '0;
      if (valid_D) begin
         dec.valid = 1'b1;
         case (opcode_D)
            OP_R: begin
               if (fun_D <= FUN_MAX) begin
                  dec.regw = 1'b1;
                  dec.alu  = ALU_CTRL_W'(fun_D);
               end else begin
                  dec.illegal = 1'b1;
               end
            end
            OP_LW: begin
               dec.regw       = 1'b1;
               dec.ext        = 1'b1;
               dec.alu_src    = 1'b1;
               dec.alu        = ALU_ADD;
               dec.result_src = 1'b1;
            end
            OP_SW: begin
               dec.ext       = 1'b1;
               dec.alu_src   = 1'b1;
               dec.alu       = ALU_ADD;
               dec.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
               dec.branch    = 1'b1;
               dec.branch_ne = opcode_D[0];
               dec.ext       = 1'b1;
               dec.alu       = ALU_SUB;
            end
            OP_ADDI, OP_SLTI: begin
               dec.regw    = 1'b1;
               dec.ext     = 1'b1;
               dec.alu_src = 1'b1;
               dec.alu     = (opcode_D == OP_ADDI) ? ALU_ADD : ALU_SLT;
            end
            // Logical immediates are zero-extended.
            OP_ANDI, OP_ORI: begin
               dec.regw    = 1'b1;
               dec.alu_src = 1'b1;
               dec.alu     = (opcode_D == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_J: begin
               dec.jump   = 1'b1;
               dec.target = target_D;
            end
            default: dec.illegal = 1'b1;
         endcase
      end
   end

   assign mul_dec = valid_D && (opcode_D == OP_R) && (fun_D == FUN_MUL);
   assign stall_D = (state_q == S_MUL);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (MUL_MULTI && mul_dec && !stall_E && !flush_E) begin
               state_d = S_MUL;
               cnt_d   = CNT_INIT;
            end
         end
         S_MUL: begin
            if (flush_E) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (!stall_E) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Flush beats stall; a running multiply holds E just like a downstream stall.
   always_comb begin
      ctrl_d = ctrl_q;
      if (flush_E)                           ctrl_d = '0;
      else if (!stall_E && state_q == S_IDLE) ctrl_d = dec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= '0;
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         ctrl_q  <= ctrl_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_E         = ctrl_q.valid;
   assign Jump_E          = ctrl_q.jump;
   assign Branch_E        = ctrl_q.branch;
   assign Branch_ne_E     = ctrl_q.branch_ne;
   assign RegW_enable_E   = ctrl_q.regw;
   assign Extend_enable_E = ctrl_q.ext;
   assign ALU_src_E       = ctrl_q.alu_src;
   assign ALU_control_E   = ctrl_q.alu;
   assign Mem_Write_E     = ctrl_q.mem_write;
   assign Result_src_E    = ctrl_q.result_src;
   assign target_E        = ctrl_q.target;
   assign illegal_E       = ctrl_q.illegal;

endmodule
